wb_read_block: RTL and testbench

Wishbone master that performs a multi-word READ block transfer with automatic address generation, in classic or pipelined (WB B4) mode. It generalises the single-transfer read framer: parametrised data/address/length widths, outstanding-request tracking, a captured read-data stream and optional retry handling. It sits between a local controller (DMA, register-dump or capture-readback logic) and a Wishbone slave or interconnect.

---
 rtl/wb_read_block.sv | 221 ++++++++++++++++++++++
 tb/tb_wb_read_block.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_read_block.sv
// Wishbone B4 block-read master: pipelined or classic, with automatic address stepping.
// Define WB_READ_BLOCK_RETRY_EN to restart on rty_i; otherwise rty_i aborts like err_i.
module wb_read_block #(
    parameter int WIDTH   = 32,
    parameter int ABITS   = 16,
    parameter int CBITS   = 4,
    parameter int PIPED   = 1,
    parameter int RETRIES = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [ABITS-1:0] adr_o,
    input  logic             ack_i,
    input  logic             wat_i,
    input  logic             rty_i,
    input  logic             err_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             read_i,
    input  logic [ABITS-1:0] addr_i,
    input  logic [CBITS-1:0] len_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             done_o,
    output logic             fail_o
);

    localparam logic [ABITS-1:0] AONE = ABITS'(1);
    localparam logic [CBITS:0]   CONE = (CBITS + 1)'(1);

    if (RETRIES < 0) begin : g_bad_retries
        $error("wb_read_block: RETRIES must be non-negative");
    end

`ifdef WB_READ_BLOCK_RETRY_EN
    localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
    typedef enum logic [1:0] {IDLE, BUS, RTRY, END} state_t;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [ABITS-1:0] base_q, base_d;
`else
    typedef enum logic [1:0] {IDLE, BUS, END} state_t;
`endif

    state_t           state_q, state_d;
    logic [CBITS-1:0] len_q, len_d;
    logic [CBITS:0]   issued_q, issued_d;
    logic [CBITS:0]   acked_q, acked_d;
    logic [CBITS:0]   issued_inc, acked_inc, total;
    logic [ABITS-1:0] adr_q, adr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             abort;

    assign total      = {1'b0, len_q} + CONE;
    assign issued_inc = issued_q + CONE;
    assign acked_inc  = acked_q + CONE;

    // Once the retry budget is spent, a further rty_i is just another error.
`ifdef WB_READ_BLOCK_RETRY_EN
    assign abort = err_i | (rty_i & (rcnt_q == RW'(RETRIES)));
`else
    assign abort = err_i | rty_i;
`endif

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        acked_d  = acked_q;
        adr_d    = adr_q;
        data_d   = data_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        done_d   = 1'b0;
        fail_d   = 1'b0;
`ifdef WB_READ_BLOCK_RETRY_EN
        rcnt_d   = rcnt_q;
        base_d   = base_q;
`endif
        case (state_q)
            IDLE, END: begin
                if (read_i) begin
                    state_d  = BUS;
                    len_d    = len_i;
                    issued_d = '0;
                    acked_d  = '0;
                    adr_d    = addr_i;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
`ifdef WB_READ_BLOCK_RETRY_EN
                    rcnt_d   = '0;
                    base_d   = addr_i;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (abort) begin
                    state_d = END;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    fail_d  = 1'b1;
                end
`ifdef WB_READ_BLOCK_RETRY_EN
                else if (rty_i) begin
                    state_d = RTRY;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    rcnt_d  = rcnt_q + RW'(1);
                end
`endif
                else begin
                    // Pipelined mode advances on each accepted request, classic mode on each ack.
                    if (PIPED != 0) begin
                        if (stb_q && !wat_i) begin
                            issued_d = issued_inc;
                            adr_d    = adr_q + AONE;
                            stb_d    = (issued_inc != total);
                        end
                    end else if (ack_i) begin
                        adr_d = adr_q + AONE;
                    end
                    if (ack_i) begin
                        acked_d = acked_inc;
                        data_d  = dat_i;
                        valid_d = 1'b1;
                        if (acked_inc == total) begin
                            state_d = END;
                            cyc_d   = 1'b0;
                            stb_d   = 1'b0;
                            last_d  = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
`ifdef WB_READ_BLOCK_RETRY_EN
            RTRY: begin
                state_d  = BUS;
                cyc_d    = 1'b1;
                stb_d    = 1'b1;
                adr_d    = base_q + ABITS'(acked_q);
                issued_d = acked_q;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef WB_READ_BLOCK_RETRY_EN
        busy_d = (state_d == BUS) || (state_d == RTRY);
`else
        busy_d = (state_d == BUS);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issued_q <= '0;
            acked_q  <= '0;
            adr_q    <= '0;
            data_q   <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
`ifdef WB_READ_BLOCK_RETRY_EN
            rcnt_q   <= '0;
            base_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            acked_q  <= acked_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
`ifdef WB_READ_BLOCK_RETRY_EN
            rcnt_q   <= rcnt_d;
            base_q   <= base_d;
`endif
        end
    end

    assign cyc_o   = cyc_q;
    assign stb_o   = stb_q;
    assign we_o    = 1'b0;
    assign adr_o   = adr_q;
    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign done_o  = done_q;
    assign fail_o  = fail_q;

endmodule

// File: tb/tb_wb_read_block.sv
// Directed self-checking bench for wb_read_block: pipelined and classic instances side by side.
// Retry scenarios follow WB_READ_BLOCK_RETRY_EN when it is defined.
module tb_wb_read_block;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] held;

    logic        p_cyc, p_stb, p_we, p_busy, p_valid, p_last, p_done, p_fail;
    logic [15:0] p_adr;
    logic [31:0] p_data;
    logic        p_ack = 1'b0, p_wat = 1'b0, p_rty = 1'b0, p_err = 1'b0, p_read = 1'b0;
    logic [31:0] p_dat = '0;
    logic [15:0] p_addr = '0;
    logic [3:0]  p_len = '0;

    logic        c_cyc, c_stb, c_we, c_busy, c_valid, c_last, c_done, c_fail;
    logic [15:0] c_adr;
    logic [31:0] c_data;
    logic        c_ack = 1'b0, c_wat = 1'b1, c_rty = 1'b0, c_err = 1'b0, c_read = 1'b0;
    logic [31:0] c_dat = '0;
    logic [15:0] c_addr = '0;
    logic [3:0]  c_len = '0;

    always #5 clk = ~clk;

    wb_read_block #(.WIDTH(32), .ABITS(16), .CBITS(4), .PIPED(1), .RETRIES(1)) u_pip (
        .clk_i(clk), .rst_ni(rst_n), .cyc_o(p_cyc), .stb_o(p_stb), .we_o(p_we), .adr_o(p_adr),
        .ack_i(p_ack), .wat_i(p_wat), .rty_i(p_rty), .err_i(p_err), .dat_i(p_dat),
        .read_i(p_read), .addr_i(p_addr), .len_i(p_len), .busy_o(p_busy), .valid_o(p_valid),
        .data_o(p_data), .last_o(p_last), .done_o(p_done), .fail_o(p_fail)
    );

    wb_read_block #(.WIDTH(32), .ABITS(16), .CBITS(4), .PIPED(0), .RETRIES(1)) u_cls (
        .clk_i(clk), .rst_ni(rst_n), .cyc_o(c_cyc), .stb_o(c_stb), .we_o(c_we), .adr_o(c_adr),
        .ack_i(c_ack), .wat_i(c_wat), .rty_i(c_rty), .err_i(c_err), .dat_i(c_dat),
        .read_i(c_read), .addr_i(c_addr), .len_i(c_len), .busy_o(c_busy), .valid_o(c_valid),
        .data_o(c_data), .last_o(c_last), .done_o(c_done), .fail_o(c_fail)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // flags = {cyc, stb, busy, valid, last, done, fail}
    task automatic applyStimulusPiped(input string tag, input logic rd, input logic ack,
                                      input logic wat, input logic rty, input logic err,
                                      input logic [31:0] dat, input logic [6:0] flags,
                                      input logic [15:0] adr, input logic [31:0] dexp);
        p_read = rd; p_ack = ack; p_wat = wat; p_rty = rty; p_err = err; p_dat = dat;
        @(posedge clk);
        #1;
        checkOutput({tag, " flags"}, {25'd0, p_cyc, p_stb, p_busy, p_valid, p_last, p_done, p_fail},
                    {25'd0, flags});
        checkOutput({tag, " adr"}, {16'd0, p_adr}, {16'd0, adr});
        checkOutput({tag, " data"}, p_data, dexp);
    endtask

    task automatic applyStimulusClassic(input string tag, input logic rd, input logic ack,
                                        input logic [31:0] dat, input logic [6:0] flags,
                                        input logic [15:0] adr, input logic [31:0] dexp);
        c_read = rd; c_ack = ack; c_dat = dat;
        @(posedge clk);
        #1;
        checkOutput({tag, " flags"}, {25'd0, c_cyc, c_stb, c_busy, c_valid, c_last, c_done, c_fail},
                    {25'd0, flags});
        checkOutput({tag, " adr"}, {16'd0, c_adr}, {16'd0, adr});
        checkOutput({tag, " data"}, c_data, dexp);
    endtask

    initial begin
        #3;
        checkOutput("rst p flags", {25'd0, p_cyc, p_stb, p_busy, p_valid, p_last, p_done, p_fail}, 32'd0);
        checkOutput("rst p adr", {16'd0, p_adr}, 32'd0);
        checkOutput("rst p data", p_data, 32'd0);
        checkOutput("rst p we", {31'd0, p_we}, 32'd0);
        checkOutput("rst c flags", {25'd0, c_cyc, c_stb, c_busy, c_valid, c_last, c_done, c_fail}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Classic: one word per ack, slave inserts two wait cycles; wat_i held high and ignored.
        c_addr = 16'h0070; c_len = 4'd1;
        applyStimulusClassic("cls1", 1, 0, 32'h0,        7'b1110000, 16'h0070, 32'h0);
        applyStimulusClassic("cls2", 0, 0, 32'h0,        7'b1110000, 16'h0070, 32'h0);
        applyStimulusClassic("cls3", 0, 0, 32'h0,        7'b1110000, 16'h0070, 32'h0);
        applyStimulusClassic("cls4", 0, 1, 32'h77770000, 7'b1111000, 16'h0071, 32'h77770000);
        applyStimulusClassic("cls5", 0, 0, 32'h0,        7'b1110000, 16'h0071, 32'h77770000);
        applyStimulusClassic("cls6", 0, 0, 32'h0,        7'b1110000, 16'h0071, 32'h77770000);
        applyStimulusClassic("cls7", 0, 1, 32'h77770001, 7'b0001110, 16'h0072, 32'h77770001);
        applyStimulusClassic("cls8", 0, 1, 32'h7777dead, 7'b0000000, 16'h0072, 32'h77770001);
        checkOutput("cls we", {31'd0, c_we}, 32'd0);
        c_ack = 1'b0;

        // Pipelined zero-wait block of four words.
        p_addr = 16'h0010; p_len = 4'd3;
        applyStimulusPiped("t1r1", 1, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0010, 32'h0);
        applyStimulusPiped("t1r2", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0011, 32'h0);
        applyStimulusPiped("t1r3", 0, 1, 0, 0, 0, 32'h11110000, 7'b1111000, 16'h0012, 32'h11110000);
        applyStimulusPiped("t1r4", 0, 1, 0, 0, 0, 32'h11110001, 7'b1111000, 16'h0013, 32'h11110001);
        applyStimulusPiped("t1r5", 0, 1, 0, 0, 0, 32'h11110002, 7'b1011000, 16'h0014, 32'h11110002);
        applyStimulusPiped("t1r6", 0, 1, 0, 0, 0, 32'h11110003, 7'b0001110, 16'h0014, 32'h11110003);

        // Stall mid-block, late acks, and a read_i while busy that must be ignored.
        p_addr = 16'h0020; p_len = 4'd3;
        applyStimulusPiped("t2r1", 1, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0020, 32'h11110003);
        p_addr = 16'h0099;
        applyStimulusPiped("t2r2", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0021, 32'h11110003);
        applyStimulusPiped("t2r3", 1, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0022, 32'h11110003);
        applyStimulusPiped("t2r4", 0, 0, 1, 0, 0, 32'h0,        7'b1110000, 16'h0022, 32'h11110003);
        applyStimulusPiped("t2r5", 0, 1, 1, 0, 0, 32'h22220000, 7'b1111000, 16'h0022, 32'h22220000);
        applyStimulusPiped("t2r6", 0, 1, 0, 0, 0, 32'h22220001, 7'b1111000, 16'h0023, 32'h22220001);
        applyStimulusPiped("t2r7", 0, 0, 0, 0, 0, 32'h0,        7'b1010000, 16'h0024, 32'h22220001);
        applyStimulusPiped("t2r8", 0, 0, 0, 0, 0, 32'h0,        7'b1010000, 16'h0024, 32'h22220001);
        applyStimulusPiped("t2r9", 0, 1, 0, 0, 0, 32'h22220002, 7'b1011000, 16'h0024, 32'h22220002);
        applyStimulusPiped("t2ra", 0, 1, 0, 0, 0, 32'h22220003, 7'b0001110, 16'h0024, 32'h22220003);
        applyStimulusPiped("t2rb", 0, 0, 0, 0, 0, 32'h0,        7'b0000000, 16'h0024, 32'h22220003);

        // Error on the second response, with a simultaneous ack that must be dropped.
        p_addr = 16'h0030; p_len = 4'd3;
        applyStimulusPiped("t3r1", 1, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0030, 32'h22220003);
        applyStimulusPiped("t3r2", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0031, 32'h22220003);
        applyStimulusPiped("t3r3", 0, 1, 0, 0, 0, 32'h33330000, 7'b1111000, 16'h0032, 32'h33330000);
        applyStimulusPiped("t3r4", 0, 1, 0, 0, 1, 32'h33330001, 7'b0000001, 16'h0032, 32'h33330000);
        applyStimulusPiped("t3r5", 0, 1, 0, 0, 0, 32'h3333dead, 7'b0000000, 16'h0032, 32'h33330000);

        // Address wrap from 0xFFFF to 0x0000.
        p_addr = 16'hFFFF; p_len = 4'd1;
        applyStimulusPiped("wr1", 1, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'hFFFF, 32'h33330000);
        applyStimulusPiped("wr2", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0000, 32'h33330000);
        applyStimulusPiped("wr3", 0, 1, 0, 0, 0, 32'h44440000, 7'b1011000, 16'h0001, 32'h44440000);
        applyStimulusPiped("wr4", 0, 1, 0, 0, 0, 32'h44440001, 7'b0001110, 16'h0001, 32'h44440001);
        applyStimulusPiped("wr5", 0, 0, 0, 0, 0, 32'h0,        7'b0000000, 16'h0001, 32'h44440001);

        // rty_i after two delivered words.
        p_addr = 16'h0040; p_len = 4'd3;
        applyStimulusPiped("ry1", 1, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0040, 32'h44440001);
        applyStimulusPiped("ry2", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0041, 32'h44440001);
        applyStimulusPiped("ry3", 0, 1, 0, 0, 0, 32'h55550000, 7'b1111000, 16'h0042, 32'h55550000);
        applyStimulusPiped("ry4", 0, 1, 0, 0, 0, 32'h55550001, 7'b1111000, 16'h0043, 32'h55550001);
`ifdef WB_READ_BLOCK_RETRY_EN
        applyStimulusPiped("ry5", 0, 0, 0, 1, 0, 32'h0,        7'b0010000, 16'h0043, 32'h55550001);
        applyStimulusPiped("ry6", 0, 1, 0, 0, 0, 32'h5555dead, 7'b1110000, 16'h0042, 32'h55550001);
        applyStimulusPiped("ry7", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0043, 32'h55550001);
        applyStimulusPiped("ry8", 0, 1, 0, 0, 0, 32'h55550002, 7'b1011000, 16'h0044, 32'h55550002);
        applyStimulusPiped("ry9", 0, 1, 0, 0, 0, 32'h55550003, 7'b0001110, 16'h0044, 32'h55550003);
        // Second run: the counter restarts at read_i, so the second rty_i exhausts RETRIES=1.
        p_addr = 16'h0050; p_len = 4'd1;
        applyStimulusPiped("rz1", 1, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0050, 32'h55550003);
        applyStimulusPiped("rz2", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0051, 32'h55550003);
        applyStimulusPiped("rz3", 0, 0, 0, 1, 0, 32'h0,        7'b0010000, 16'h0051, 32'h55550003);
        applyStimulusPiped("rz4", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0050, 32'h55550003);
        applyStimulusPiped("rz5", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0051, 32'h55550003);
        applyStimulusPiped("rz6", 0, 0, 0, 1, 0, 32'h0,        7'b0000001, 16'h0051, 32'h55550003);
        applyStimulusPiped("rz7", 0, 0, 0, 0, 0, 32'h0,        7'b0000000, 16'h0051, 32'h55550003);
        held = 32'h55550003;
`else
        applyStimulusPiped("ry5", 0, 0, 0, 1, 0, 32'h0,        7'b0000001, 16'h0043, 32'h55550001);
        applyStimulusPiped("ry6", 0, 0, 0, 0, 0, 32'h0,        7'b0000000, 16'h0043, 32'h55550001);
        held = 32'h55550001;
`endif

        // Asynchronous reset in the middle of a block.
        p_addr = 16'h0060; p_len = 4'd3;
        applyStimulusPiped("rs1", 1, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0060, held);
        applyStimulusPiped("rs2", 0, 0, 0, 0, 0, 32'h0,        7'b1110000, 16'h0061, held);
        applyStimulusPiped("rs3", 0, 1, 0, 0, 0, 32'h66660000, 7'b1111000, 16'h0062, 32'h66660000);
        rst_n = 1'b0;
        #1;
        checkOutput("mid rst flags", {25'd0, p_cyc, p_stb, p_busy, p_valid, p_last, p_done, p_fail}, 32'd0);
        checkOutput("mid rst adr", {16'd0, p_adr}, 32'd0);
        checkOutput("mid rst data", p_data, 32'd0);
        p_ack = 1'b0; p_read = 1'b0;
        @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post rst flags", {25'd0, p_cyc, p_stb, p_busy, p_valid, p_last, p_done, p_fail}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
